// File: rtl/load_issue_scheduler_pkg.sv
// Shared constants and state encoding for the load issue scheduler slice.
package load_issue_scheduler_pkg;

    localparam int LQ_NUM_DEF     = 8;
    localparam int LQ_SEL_DEF     = 3;
    localparam int ADDR_WIDTH_DEF = 32;
    localparam int DATA_WIDTH_DEF = 32;
    localparam int ROB_SEL_DEF    = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } lis_state_e;

endpackage

// File: rtl/rr_age_picker.sv
// Oldest-first picker: grants the first requesting index reached scanning
// upward from base, wrapping modulo NUM.
module rr_age_picker
    import load_issue_scheduler_pkg::*;
#(
    parameter int NUM = LQ_NUM_DEF,
    parameter int SEL = LQ_SEL_DEF
) (
    input  logic [NUM-1:0] req,
    input  logic [SEL-1:0] base,
    output logic           gnt_valid,
    output logic [SEL-1:0] gnt_idx
);

    logic [SEL-1:0] idx;

    // Scan from the youngest offset down so the smallest offset hit is the final winner.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        idx       = '0;
        for (int i = NUM - 1; i >= 0; i--) begin
            idx = base + SEL'(i);
            if (req[idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = idx;
            end
        end
    end

endmodule

// File: rtl/load_issue_scheduler.sv
// Issues one ready load at a time to the data cache, oldest-first from the
// load-queue head, and writes back hits; misses return the entry for replay.
module load_issue_scheduler
    import load_issue_scheduler_pkg::*;
#(
    parameter int LQ_NUM     = LQ_NUM_DEF,
    parameter int LQ_SEL     = LQ_SEL_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ROB_SEL    = ROB_SEL_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [LQ_NUM-1:0]     lq_cand_vec,
    input  logic [LQ_SEL-1:0]     lq_head,
    output logic [LQ_SEL-1:0]     lq_rd_idx,
    input  logic [ADDR_WIDTH-1:0] lq_rd_addr,
    input  logic [ROB_SEL-1:0]    lq_rd_rob,
    input  logic                  flush,
    output logic                  dc_req_valid,
    output logic [ADDR_WIDTH-1:0] dc_req_addr,
    input  logic                  dc_req_ready,
    input  logic                  dc_resp_valid,
    input  logic                  dc_resp_miss,
    input  logic [DATA_WIDTH-1:0] dc_resp_data,
    output logic                  wb_valid,
    output logic [ROB_SEL-1:0]    wb_rob_idx,
    output logic [DATA_WIDTH-1:0] wb_data,
    output logic                  busy
);

    lis_state_e            state, state_nxt;
    logic [LQ_NUM-1:0]     issued, issued_nxt;
    logic [LQ_NUM-1:0]     eligible;
    logic                  gnt_valid;
    logic [LQ_SEL-1:0]     gnt_idx;
    logic                  latch_en;
    logic                  wb_fire;

    logic [LQ_SEL-1:0]     sel_idx_p0;
    logic [ADDR_WIDTH-1:0] req_addr_p0;
    logic [ROB_SEL-1:0]    req_rob_p0;

    assign eligible = lq_cand_vec & ~issued;

    rr_age_picker #(
        .NUM (LQ_NUM),
        .SEL (LQ_SEL)
    ) u_picker (
        .req       (eligible),
        .base      (lq_head),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    // The load queue is read at the live winner while idle, at the held entry otherwise.
    assign lq_rd_idx   = (state == ST_IDLE) ? gnt_idx : sel_idx_p0;
    assign dc_req_addr = req_addr_p0;
    assign busy        = (state != ST_IDLE);

    always_comb begin
        state_nxt    = state;
        issued_nxt   = issued;
        latch_en     = 1'b0;
        wb_fire      = 1'b0;
        dc_req_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                if (flush) begin
                    issued_nxt = '0;
                end else if (gnt_valid) begin
                    latch_en            = 1'b1;
                    issued_nxt[gnt_idx] = 1'b1;
                    state_nxt           = ST_REQ;
                end
            end
            ST_REQ: begin
                if (flush) begin
                    issued_nxt = '0;
                    state_nxt  = ST_IDLE;
                end else begin
                    dc_req_valid = 1'b1;
                    if (dc_req_ready) begin
                        state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // A flush racing the response still consumes it, so no drain is needed.
                if (flush) begin
                    issued_nxt = '0;
                    state_nxt  = dc_resp_valid ? ST_IDLE : ST_DRAIN;
                end else if (dc_resp_valid) begin
                    issued_nxt[sel_idx_p0] = 1'b0;
                    wb_fire                = ~dc_resp_miss;
                    state_nxt              = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (flush) begin
                    issued_nxt = '0;
                end
                if (dc_resp_valid) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt  = ST_IDLE;
                issued_nxt = '0;
            end
        endcase
    end

    // Stage p0: request fields captured at selection time.
    always_ff @(posedge clk) begin
        if (latch_en) begin
            sel_idx_p0  <= gnt_idx;
            req_addr_p0 <= lq_rd_addr;
            req_rob_p0  <= lq_rd_rob;
        end
    end

    // Stage p1: control state and writeback.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            issued     <= '0;
            wb_valid   <= 1'b0;
            wb_rob_idx <= '0;
            wb_data    <= '0;
        end else begin
            state    <= state_nxt;
            issued   <= issued_nxt;
            wb_valid <= wb_fire;
            if (wb_fire) begin
                wb_rob_idx <= req_rob_p0;
                wb_data    <= dc_resp_data;
            end
        end
    end

endmodule

// File: tb/tb_load_issue_scheduler.sv
// Randomized and directed bench for load_issue_scheduler against a
// transaction-level model of oldest-first issue and response handling.
module tb_load_issue_scheduler;

    localparam int LQ_NUM     = 8;
    localparam int LQ_SEL     = 3;
    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;
    localparam int ROB_SEL    = 6;

    localparam int K_HIT        = 0;
    localparam int K_MISS       = 1;
    localparam int K_FLUSH_WAIT = 2;
    localparam int K_FLUSH_RESP = 3;
    localparam int K_FLUSH_REQ  = 4;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [LQ_NUM-1:0]     lq_cand_vec;
    logic [LQ_SEL-1:0]     lq_head;
    logic [LQ_SEL-1:0]     lq_rd_idx;
    logic [ADDR_WIDTH-1:0] lq_rd_addr;
    logic [ROB_SEL-1:0]    lq_rd_rob;
    logic                  flush;
    logic                  dc_req_valid;
    logic [ADDR_WIDTH-1:0] dc_req_addr;
    logic                  dc_req_ready;
    logic                  dc_resp_valid;
    logic                  dc_resp_miss;
    logic [DATA_WIDTH-1:0] dc_resp_data;
    logic                  wb_valid;
    logic [ROB_SEL-1:0]    wb_rob_idx;
    logic [DATA_WIDTH-1:0] wb_data;
    logic                  busy;

    logic [ADDR_WIDTH-1:0] mem_addr [LQ_NUM];
    logic [ROB_SEL-1:0]    mem_rob  [LQ_NUM];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign lq_rd_addr = mem_addr[lq_rd_idx];
    assign lq_rd_rob  = mem_rob[lq_rd_idx];

    load_issue_scheduler #(
        .LQ_NUM     (LQ_NUM),
        .LQ_SEL     (LQ_SEL),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .ROB_SEL    (ROB_SEL)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .lq_cand_vec   (lq_cand_vec),
        .lq_head       (lq_head),
        .lq_rd_idx     (lq_rd_idx),
        .lq_rd_addr    (lq_rd_addr),
        .lq_rd_rob     (lq_rd_rob),
        .flush         (flush),
        .dc_req_valid  (dc_req_valid),
        .dc_req_addr   (dc_req_addr),
        .dc_req_ready  (dc_req_ready),
        .dc_resp_valid (dc_resp_valid),
        .dc_resp_miss  (dc_resp_miss),
        .dc_resp_data  (dc_resp_data),
        .wb_valid      (wb_valid),
        .wb_rob_idx    (wb_rob_idx),
        .wb_data       (wb_data),
        .busy          (busy)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Oldest-first: first candidate at or after head, wrapping; -1 if none.
    function automatic int model_pick(input logic [LQ_NUM-1:0] cand, input int head);
        for (int i = 0; i < LQ_NUM; i++) begin
            if (cand[(head + i) % LQ_NUM]) return (head + i) % LQ_NUM;
        end
        return -1;
    endfunction

    task automatic randomize_mem();
        for (int i = 0; i < LQ_NUM; i++) begin
            mem_addr[i] = $urandom;
            mem_rob[i]  = ROB_SEL'($urandom_range(63, 0));
        end
    endtask

    // Starts with the scheduler idle, 1 time unit after a rising edge, and leaves it idle likewise.
    task automatic run_txn(input logic [LQ_NUM-1:0] cand, input int head, input int stall,
                           input int kind, input int lat, input logic [DATA_WIDTH-1:0] data);
        int exp;
        exp         = model_pick(cand, head);
        lq_cand_vec = cand;
        lq_head     = LQ_SEL'(head);
        #1;
        if (exp >= 0) check_val("rd_idx_idle", lq_rd_idx, exp);
        step();
        check_val("wb_single", wb_valid, 0);
        if (exp < 0) begin
            check_val("idle_no_cand", busy, 0);
            return;
        end
        check_val("req_busy", busy, 1);
        check_val("req_valid", dc_req_valid, 1);
        check_val("req_addr", dc_req_addr, mem_addr[exp]);
        check_val("rd_idx_held", lq_rd_idx, exp);
        for (int s = 0; s < stall; s++) begin
            dc_req_ready = 1'b0;
            step();
            check_val("stall_valid", dc_req_valid, 1);
            check_val("stall_addr", dc_req_addr, mem_addr[exp]);
        end
        if (kind == K_FLUSH_REQ) begin
            flush        = 1'b1;
            dc_req_ready = 1'($urandom_range(1, 0));
            #1;
            check_val("flush_req_drop", dc_req_valid, 0);
            step();
            flush        = 1'b0;
            dc_req_ready = 1'b0;
            check_val("flush_req_idle", busy, 0);
            return;
        end
        dc_req_ready = 1'b1;
        step();
        dc_req_ready = 1'b0;
        check_val("wait_valid", dc_req_valid, 0);
        check_val("wait_busy", busy, 1);
        if (kind == K_FLUSH_WAIT) begin
            flush = 1'b1;
            step();
            flush = 1'b0;
            check_val("drain_busy", busy, 1);
        end
        for (int l = 0; l < lat; l++) begin
            step();
            check_val("pending_busy", busy, 1);
            check_val("pending_wb", wb_valid, 0);
        end
        dc_resp_valid = 1'b1;
        dc_resp_miss  = (kind == K_MISS);
        dc_resp_data  = data;
        flush         = (kind == K_FLUSH_RESP);
        step();
        dc_resp_valid = 1'b0;
        dc_resp_miss  = 1'b0;
        flush         = 1'b0;
        check_val("resp_idle", busy, 0);
        check_val("resp_wb", wb_valid, (kind == K_HIT));
        if (kind == K_HIT) begin
            check_val("wb_rob", wb_rob_idx, mem_rob[exp]);
            check_val("wb_data", wb_data, data);
        end
    endtask

    initial begin
        reset         = 1'b1;
        lq_cand_vec   = '0;
        lq_head       = '0;
        flush         = 1'b0;
        dc_req_ready  = 1'b0;
        dc_resp_valid = 1'b0;
        dc_resp_miss  = 1'b0;
        dc_resp_data  = '0;
        randomize_mem();
        #2;
        check_val("rst_busy", busy, 0);
        check_val("rst_req_valid", dc_req_valid, 0);
        check_val("rst_wb_valid", wb_valid, 0);
        check_val("rst_wb_rob", wb_rob_idx, 0);
        check_val("rst_wb_data", wb_data, 0);
        step();
        reset = 1'b0;

        // Wrap past the end of the queue to reach entry 0.
        run_txn(8'b0100_0001, 7, 0, K_HIT, 1, 32'hCAFE_0001);
        // Head on a set entry picks that entry.
        run_txn(8'b0100_0001, 6, 0, K_HIT, 0, 32'hCAFE_0002);
        // Three-cycle ready stall.
        run_txn(8'b0011_0000, 3, 3, K_HIT, 2, 32'hCAFE_0003);
        // Miss on entry 2 then replay of the same entry.
        run_txn(8'b1000_0100, 1, 0, K_MISS, 1, 32'h0BAD_0BAD);
        run_txn(8'b1000_0100, 1, 0, K_HIT, 0, 32'hCAFE_0004);
        // Flush while waiting; the response two cycles later is dropped.
        run_txn(8'b0000_1000, 0, 1, K_FLUSH_WAIT, 2, 32'h0000_DEAD);
        // Hit with known rob tag and data.
        mem_rob[5] = 6'h15;
        run_txn(8'b0010_0000, 2, 0, K_HIT, 1, 32'h1234_5678);
        // Flush in REQ and flush racing the response.
        run_txn(8'b0000_0010, 0, 1, K_FLUSH_REQ, 0, '0);
        run_txn(8'b0000_0010, 0, 0, K_FLUSH_RESP, 1, 32'h5555_AAAA);
        // No candidates leaves the scheduler idle.
        run_txn(8'b0000_0000, 4, 0, K_HIT, 0, '0);

        // Flush held in IDLE blocks selection.
        lq_cand_vec = 8'b0000_0001;
        flush       = 1'b1;
        step();
        check_val("flush_idle_block", busy, 0);
        flush = 1'b0;

        // Reset asserted mid-request.
        lq_cand_vec = 8'b0001_0000;
        lq_head     = '0;
        step();
        check_val("pre_rst_valid", dc_req_valid, 1);
        #2;
        reset = 1'b1;
        #1;
        check_val("rst_mid_valid", dc_req_valid, 0);
        check_val("rst_mid_busy", busy, 0);
        @(posedge clk);
        #1;
        reset         = 1'b0;
        lq_cand_vec   = '0;
        dc_resp_valid = 1'b1;
        dc_resp_data  = 32'hFFFF_0000;
        step();
        dc_resp_valid = 1'b0;
        check_val("stale_resp_wb", wb_valid, 0);
        check_val("stale_resp_busy", busy, 0);
        run_txn(8'b0001_0000, 0, 0, K_HIT, 0, 32'hCAFE_0005);

        for (int t = 0; t < 300; t++) begin
            logic [LQ_NUM-1:0] cand;
            randomize_mem();
            cand = LQ_NUM'($urandom);
            if ($urandom_range(7, 0) == 0) cand = '0;
            run_txn(cand, int'($urandom_range(LQ_NUM - 1, 0)), int'($urandom_range(3, 0)),
                    int'($urandom_range(4, 0)), int'($urandom_range(2, 0)), $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
